// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control unit and the multiply/divide unit.
interface mult_div_unit_if;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT (radix-2 Booth) / DIV (restoring on magnitudes) unit
// writing a 64-bit result into HI/LO, one iteration per clock.
module mult_div_unit (
  input  logic             clock,
  input  logic             reset,
  mult_div_unit_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_op;
  logic [31:0] r_a;
  logic        r_b_sgn;
  logic [5:0]  r_cnt;
  logic [64:0] r_prod;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dmag;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_dz;

  logic        w_accept;
  logic        w_dz;
  logic        w_last;
  logic [31:0] w_amag;
  logic [31:0] w_bmag;
  logic [32:0] w_mcand;
  logic [32:0] w_upper;
  logic [32:0] w_sum;
  logic [64:0] w_booth;
  logic [32:0] w_shift;
  logic [32:0] w_diff;
  logic        w_qbit;
  logic [31:0] w_rem_next;

  assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start;
  assign w_dz     = w_accept && bus.op && (bus.b == '0);
  assign w_last   = (r_cnt == 6'd31);

  // |0x80000000| wraps to itself, which is the correct unsigned magnitude.
  assign w_amag = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
  assign w_bmag = bus.b[31] ? (~bus.b + 32'd1) : bus.b;

  // Booth step: 33-bit add/sub on the upper half keeps -(-2^31) exact.
  assign w_mcand = {r_a[31], r_a};
  assign w_upper = {r_prod[64], r_prod[64:33]};
  always_comb begin
    w_sum = w_upper;
    case (r_prod[1:0])
      2'b01:   w_sum = w_upper + w_mcand;
      2'b10:   w_sum = w_upper - w_mcand;
      default: w_sum = w_upper;
    endcase
  end
  assign w_booth = {w_sum, r_prod[32:1]};

  // Restoring step: remainder stays below the divisor, so 33 bits give a true sign.
  assign w_shift    = {r_rem, r_quo[31]};
  assign w_diff     = w_shift - {1'b0, r_dmag};
  assign w_qbit     = ~w_diff[32];
  assign w_rem_next = w_qbit ? w_diff[31:0] : w_shift[31:0];

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          if (w_dz)        w_next = S_DONE;
          else if (bus.op) w_next = S_DIV;
          else             w_next = S_MULT;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_MULT:  w_next = w_last ? S_FIX : S_MULT;
      S_DIV:   w_next = w_last ? S_FIX : S_DIV;
      S_FIX:   w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (r_state)
      S_MULT, S_DIV, S_FIX: bus.busy = 1'b1;
      S_DONE:               bus.done = 1'b1;
      default: begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
      end
    endcase
  end

  assign bus.div_zero = r_dz;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_op    <= 1'b0;
      r_a     <= '0;
      r_b_sgn <= 1'b0;
      r_cnt   <= '0;
      r_prod  <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dmag  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_dz <= w_dz;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_op    <= bus.op;
            r_a     <= bus.a;
            r_b_sgn <= bus.b[31];
            r_cnt   <= '0;
            r_prod  <= {32'd0, bus.b, 1'b0};
            r_rem   <= '0;
            r_quo   <= w_amag;
            r_dmag  <= w_bmag;
          end
        end
        S_MULT: begin
          r_prod <= w_booth;
          r_cnt  <= r_cnt + 6'd1;
        end
        S_DIV: begin
          r_rem  <= w_rem_next;
          r_quo  <= {r_quo[30:0], w_qbit};
          r_cnt  <= r_cnt + 6'd1;
        end
        S_FIX: begin
          if (r_op) begin
            r_lo <= (r_a[31] ^ r_b_sgn) ? (~r_quo + 32'd1) : r_quo;
            r_hi <= r_a[31] ? (~r_rem + 32'd1) : r_rem;
          end else begin
            r_hi <= r_prod[64:33];
            r_lo <= r_prod[32:1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed and random MULT/DIV against
// an arithmetic reference, plus divide-by-zero, back-to-back and abort cases.
module tb_mult_div_unit;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mult_div_unit_if bus ();

  mult_div_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void model(input bit op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output bit dz);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    h  = m_hi;
    l  = m_lo;
    if (!op) begin
      p = sa * sb;
      h = p[63:32];
      l = p[31:0];
    end else if (b == 32'd0) begin
      dz = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      l = q[31:0];
      h = r[31:0];
    end
  endfunction

  // Caller must be positioned between a negedge and the following posedge.
  task automatic do_op(input bit op, input logic [31:0] a, input logic [31:0] b, input string name);
    logic [31:0] eh, el;
    bit edz, busy_ok, hold_ok;
    int lat;
    model(op, a, b, eh, el, edz);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.op = 1'($urandom); bus.a = $urandom; bus.b = $urandom;
    lat = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    while (lat < 100) begin
      @(negedge clock);
      if (bus.done) break;
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.hi !== m_hi || bus.lo !== m_lo) hold_ok = 1'b0;
      lat++;
    end
    n_checks++; if (lat !== (edz ? 0 : 33)) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, edz ? 0 : 33); end
    n_checks++; if (bus.hi !== eh) begin n_fail++; $display("FAIL %s hi: got %h want %h", name, bus.hi, eh); end
    n_checks++; if (bus.lo !== el) begin n_fail++; $display("FAIL %s lo: got %h want %h", name, bus.lo, el); end
    n_checks++; if (bus.div_zero !== edz) begin n_fail++; $display("FAIL %s div_zero: got %b want %b", name, bus.div_zero, edz); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_at_done: got %b want 0", name, bus.busy); end
    if (!edz) begin
      n_checks++; if (busy_ok !== 1'b1) begin n_fail++; $display("FAIL %s busy_during_op: got dropped want held", name); end
      n_checks++; if (hold_ok !== 1'b1) begin n_fail++; $display("FAIL %s hilo_hold: got changed want %h_%h", name, m_hi, m_lo); end
    end
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic idle_cycle(input string name);
    @(negedge clock);
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL %s done_pulse: got %b want 0", name, bus.done); end
    n_checks++; if (bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL %s dz_clear: got %b want 0", name, bus.div_zero); end
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    n_checks++; if ({bus.hi, bus.lo} !== 64'd0) begin n_fail++; $display("FAIL reset_hilo: got %h want 0", {bus.hi, bus.lo}); end
    n_checks++; if ({bus.busy, bus.done, bus.div_zero} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {bus.busy, bus.done, bus.div_zero}); end
  endtask

  task automatic test_mult_directed();
    do_op(1'b0, 32'd6, 32'd7, "mult_6x7");               idle_cycle("mult_6x7");
    do_op(1'b0, 32'hFFFFFFFD, 32'd5, "mult_m3x5");       idle_cycle("mult_m3x5");
    do_op(1'b0, 32'h80000000, 32'h80000000, "mult_min"); idle_cycle("mult_min");
    do_op(1'b0, 32'h7FFFFFFF, 32'h80000000, "mult_max_min"); idle_cycle("mult_max_min");
  endtask

  task automatic test_div_directed();
    do_op(1'b1, 32'd7, 32'hFFFFFFFE, "div_7_m2");        idle_cycle("div_7_m2");
    do_op(1'b1, 32'hFFFFFFF9, 32'd2, "div_m7_2");        idle_cycle("div_m7_2");
    do_op(1'b1, 32'h80000000, 32'hFFFFFFFF, "div_min_m1"); idle_cycle("div_min_m1");
    do_op(1'b1, 32'd3, 32'h80000000, "div_3_min");       idle_cycle("div_3_min");
  endtask

  task automatic test_div_zero();
    do_op(1'b1, 32'd5, 32'd2, "div_5_2");   idle_cycle("div_5_2");
    do_op(1'b1, 32'd100, 32'd0, "div_by0"); idle_cycle("div_by0");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    bit op;
    for (int unsigned i = 0; i < 40; i++) begin
      op = 1'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'($urandom_range(1, 15));
        1: b = -32'($urandom_range(1, 15));
        2: a = 32'h80000000;
        3: a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      do_op(op, a, b, op ? "rand_div" : "rand_mult");
      if ($urandom_range(0, 1) == 0) idle_cycle("rand_gap");
    end
  endtask

  task automatic test_back_to_back();
    do_op(1'b0, 32'd1234, 32'hFFFF0000, "b2b_mult");
    do_op(1'b1, 32'd1000, 32'd7, "b2b_div");
    do_op(1'b1, 32'd55, 32'd0, "b2b_dz");
    do_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, "b2b_after_dz");
    idle_cycle("b2b_end");
  endtask

  task automatic test_abort();
    bit saw_done, busy_ok, late_done;
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'd3; bus.b = 32'd4;
    @(posedge clock); #1;
    bus.start = 1'b0;
    saw_done = 1'b0; busy_ok = 1'b1;
    for (int unsigned c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (bus.done) saw_done = 1'b1;
      if (!bus.busy) busy_ok = 1'b0;
      bus.start = (c == 10); bus.op = 1'b1; bus.a = 32'd9; bus.b = 32'd3;
    end
    bus.start = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    n_checks++; if ({bus.hi, bus.lo} !== 64'd0) begin n_fail++; $display("FAIL abort_hilo: got %h want 0", {bus.hi, bus.lo}); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_early_done: got %b want 0", saw_done); end
    n_checks++; if (busy_ok !== 1'b1) begin n_fail++; $display("FAIL abort_busy_held: got %b want 1", busy_ok); end
    late_done = 1'b0;
    for (int unsigned c = 0; c < 40; c++) begin
      @(negedge clock);
      if (bus.done || bus.busy) late_done = 1'b1;
    end
    n_checks++; if (late_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b want 0", late_done); end
    do_op(1'b0, 32'd3, 32'd4, "after_abort");
    idle_cycle("after_abort");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_mult_directed();
    test_div_directed();
    test_div_zero();
    test_random();
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
